// File: rtl/miriscv_data_ram.sv
// Single-port data RAM for the miriscv core: single-cycle stores, loads with a
// configurable fixed latency and a one-cycle rvalid pulse.
module miriscv_data_ram #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  output logic            data_rvalid_o,
  output logic [XLEN-1:0] data_rdata_o
);

  localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [XLEN:0] ByteSize = (XLEN + 1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [AW-1:0]     idx_q;
  logic              in_range_q;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  logic [XLEN-1:0]   offset;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic              do_write;

  // Range check on the offset so BASE_ADDR + size may not wrap.
  always_comb begin
    offset   = data_addr_i - BASE_ADDR;
    in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, offset} < ByteSize);
    idx      = AW'(offset >> 2);
    do_write = !rst_i && (state_q == S_IDLE) && data_req_i && data_we_i && in_range;
  end

  // Array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      in_range_q    <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
    end else begin
      data_rvalid_o <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (data_req_i && !data_we_i) begin
            idx_q      <= idx;
            in_range_q <= in_range;
            if (READ_LATENCY <= 1) begin
              state_q       <= S_RESP;
              data_rvalid_o <= 1'b1;
              data_rdata_o  <= in_range ? mem[idx] : '0;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CntW'(READ_LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          // Array is sampled on the edge entering S_RESP.
          if (cnt_q <= CntW'(1)) begin
            state_q       <= S_RESP;
            cnt_q         <= '0;
            data_rvalid_o <= 1'b1;
            data_rdata_o  <= in_range_q ? mem[idx_q] : '0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_data_ram.sv
// Directed bench for miriscv_data_ram: eight instances, READ_LATENCY 1..8,
// sharing all inputs except the per-instance request.
module tb_miriscv_data_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rv [8];
  logic [31:0] rd [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_dut
    miriscv_data_ram #(
      .XLEN        (32),
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .READ_LATENCY(g + 1)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_req_i   (req[g]),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_addr_i  (addr),
      .data_wdata_i (wdata),
      .data_rvalid_o(rv[g]),
      .data_rdata_o (rd[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
    req    = '0;
    req[i] = 1'b1;
    we     = 1'b1;
    addr   = a;
    wdata  = d;
    be     = b;
    tick();
    req = '0;
    we  = 1'b0;
    be  = 4'h0;
  endtask

  // Holds the request through the S_RESP edge, then counts stray pulses.
  task automatic do_load(input int i, input logic [31:0] a, input bit disturb,
                         output logic [31:0] data, output int lat, output int extra);
    req    = '0;
    req[i] = 1'b1;
    we     = 1'b0;
    be     = 4'h0;
    addr   = a;
    tick();
    lat = 1;
    if (disturb) begin
      we    = 1'b1;
      be    = 4'hF;
      addr  = a + 32'h4;
      wdata = 32'hBAD0_BAD0;
    end
    while (rv[i] !== 1'b1 && lat < 20) begin
      tick();
      lat++;
      if (disturb) addr = a + 32'h4 + 32'(lat);
    end
    data = rd[i];
    tick();
    req   = '0;
    we    = 1'b0;
    be    = 4'h0;
    addr  = a;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      if (rv[i] !== 1'b0) extra++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rv[i] !== 1'b0 || rd[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: rvalid=%b rdata=%h, required rvalid=0 rdata=0",
                 i, rv[i], rd[i]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_store();
    logic [31:0] d; int lat; int extra;
    do_store(1, 32'h40, 32'h1111_1111, 4'hF);
    rst = 1'b1; req[1] = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h2222_2222; be = 4'hF;
    tick();
    rst = 1'b0; req = '0; we = 1'b0; be = 4'h0;
    do_load(1, 32'h40, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL store_during_reset: rdata=%h, required 11111111", d);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; int lat; int extra;
    do_store(1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    do_load(1, 32'h10, 1'b0, d, lat, extra);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL basic_latency: rvalid after %0d cycles, required 2", lat);
    end
    n_tests++;
    if (d !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL basic_rdata: rdata=%h, required deadbeef", d);
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL basic_single_pulse: %0d extra rvalid cycles, required 0", extra);
    end
    n_tests++;
    if (rd[1] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL basic_rdata_hold: rdata=%h after response, required deadbeef", rd[1]);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] d; int lat; int extra;
    do_store(1, 32'h20, 32'h0000_0000, 4'hF);
    do_store(1, 32'h22, 32'hAAAA_AAAA, 4'b0100);
    do_load(1, 32'h20, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h00AA_0000) begin
      n_fail++;
      $display("FAIL byte_lane2: rdata=%h, required 00aa0000", d);
    end
    do_store(1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    do_load(1, 32'h20, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h00AA_0000) begin
      n_fail++;
      $display("FAIL byte_be_zero: rdata=%h, required 00aa0000", d);
    end
    do_store(1, 32'h21, 32'h1234_5678, 4'b1001);
    do_load(1, 32'h20, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h12AA_0078) begin
      n_fail++;
      $display("FAIL byte_lanes_0_3: rdata=%h, required 12aa0078", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; int lat; int extra;
    logic [31:0] exp_v [3];
    exp_v[0] = 32'h0101_0101; exp_v[1] = 32'h0202_0202; exp_v[2] = 32'h0303_0303;
    do_store(1, 32'h30, exp_v[0], 4'hF);
    do_store(1, 32'h34, exp_v[1], 4'hF);
    do_store(1, 32'h38, exp_v[2], 4'hF);
    for (int k = 0; k < 3; k++) begin
      do_load(1, 32'h30 + 32'(4 * k), 1'b0, d, lat, extra);
      n_tests++;
      if (d !== exp_v[k]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: rdata=%h, required %h", k, d, exp_v[k]);
      end
    end
  endtask

  task automatic test_held_request();
    logic [31:0] d; int lat; int extra;
    do_store(1, 32'h50, 32'h5555_5555, 4'hF);
    do_store(1, 32'h54, 32'h7777_7777, 4'hF);
    do_store(1, 32'h58, 32'h9999_9999, 4'hF);
    do_load(1, 32'h50, 1'b1, d, lat, extra);
    n_tests++;
    if (d !== 32'h5555_5555 || lat !== 2) begin
      n_fail++;
      $display("FAIL held_load: rdata=%h lat=%0d, required 55555555 lat=2", d, lat);
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL held_single_pulse: %0d extra rvalid cycles, required 0", extra);
    end
    do_load(1, 32'h54, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h7777_7777) begin
      n_fail++;
      $display("FAIL held_no_write_54: rdata=%h, required 77777777", d);
    end
    do_load(1, 32'h58, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h9999_9999) begin
      n_fail++;
      $display("FAIL held_no_write_58: rdata=%h, required 99999999", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; int lat; int extra;
    do_store(1, 32'h0, 32'h0000_ABCD, 4'hF);
    do_store(1, 32'hFFC, 32'hC0FF_EE00, 4'hF);
    do_store(1, 32'h1000, 32'hDEAD_DEAD, 4'hF);
    do_load(1, 32'h0, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h0000_ABCD) begin
      n_fail++;
      $display("FAIL oob_word0_intact: rdata=%h, required 0000abcd", d);
    end
    do_load(1, 32'hFFC, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'hC0FF_EE00) begin
      n_fail++;
      $display("FAIL oob_last_word: rdata=%h, required c0ffee00", d);
    end
    do_load(1, 32'h1000, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h0 || lat !== 2 || extra !== 0) begin
      n_fail++;
      $display("FAIL oob_load: rdata=%h lat=%0d extra=%0d, required 0 lat=2 extra=0",
               d, lat, extra);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; int lat; int extra; int stray;
    do_store(3, 32'h60, 32'h1357_9BDF, 4'hF);
    req = '0; req[3] = 1'b1; we = 1'b0; addr = 32'h60;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = '0;
    n_tests++;
    if (rd[3] !== 32'h0 || rv[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset_outputs: rvalid=%b rdata=%h, required 0/0", rv[3], rd[3]);
    end
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (rv[3] !== 1'b0) stray++;
      tick();
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL abort_no_rvalid: %0d rvalid cycles after reset, required 0", stray);
    end
    do_load(3, 32'h60, 1'b0, d, lat, extra);
    n_tests++;
    if (d !== 32'h1357_9BDF || lat !== 4) begin
      n_fail++;
      $display("FAIL abort_reload: rdata=%h lat=%0d, required 13579bdf lat=4", d, lat);
    end
  endtask

  task automatic test_latency_sweep();
    logic [31:0] d; logic [31:0] exp_d; int lat; int extra;
    for (int i = 0; i < 8; i++) begin
      exp_d = 32'hA500_0000 | 32'(i * 32'h0101);
      do_store(i, 32'h80, exp_d, 4'hF);
      do_load(i, 32'h80, 1'b0, d, lat, extra);
      n_tests++;
      if (lat !== i + 1 || d !== exp_d || extra !== 0) begin
        n_fail++;
        $display("FAIL sweep_lat%0d: lat=%0d rdata=%h extra=%0d, required lat=%0d rdata=%h extra=0",
                 i + 1, lat, d, extra, i + 1, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_store();
    test_basic();
    test_byte_enables();
    test_back_to_back();
    test_held_request();
    test_out_of_range();
    test_reset_abort();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
